// File: rtl/second_layer_ctrl.sv
// ============================================================================
// Module   : second_layer_ctrl
// Purpose  : Sequences start/backprop/update pulses to the second-layer cells
//            and collects their completion pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module second_layer_ctrl #(
  parameter int NOUT     = 10,
  parameter int TO_BITS  = 12,
  parameter int TIMEOUT  = 4000,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  output logic                cmd_ready,
  output logic                start_state2,
  output logic                start_backprop,
  output logic                update_second_layer,
  input  logic [NOUT-1:0]     end_state2,
  input  logic [NOUT-1:0]     end_state4,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                err_sticky,
  output logic [CNT_BITS-1:0] fwd_count
);

  localparam logic [1:0] OP_FWD = 2'd0;
  localparam logic [1:0] OP_BP  = 2'd1;
  localparam logic [1:0] OP_UPD = 2'd2;
  localparam logic [TO_BITS-1:0] TO_LIM = TO_BITS'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [1:0]           op_r;
  logic [NOUT-1:0]      mask;
  logic [NOUT-1:0]      end_sel;
  logic [NOUT-1:0]      merged;
  logic                 all_done;
  logic [TO_BITS-1:0]   wd;
  logic [TO_BITS-1:0]   wd_inc;
  logic                 wd_hit;
  logic                 err_pend;
  logic                 err_sticky_r;
  logic [CNT_BITS-1:0]  cnt;

  // Only the completion bus matching the active command is observed.
  always_comb begin
    end_sel = '0;
    case (op_r)
      OP_FWD:  end_sel = end_state2;
      OP_BP:   end_sel = end_state4;
      default: end_sel = '0;
    endcase
  end

  assign merged   = mask | end_sel;
  assign all_done = &merged;
  assign wd_inc   = wd + TO_BITS'(1);
  assign wd_hit   = (wd_inc == TO_LIM);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = ((op_r == OP_FWD) || (op_r == OP_BP)) ? S_WAIT : S_DONE;
      S_WAIT:  if (all_done || wd_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state        <= S_IDLE;
      op_r         <= OP_FWD;
      mask         <= '0;
      wd           <= '0;
      err_pend     <= 1'b0;
      err_sticky_r <= 1'b0;
      cnt          <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          err_pend <= 1'b0;
          if (cmd_valid) op_r <= cmd_op;
        end
        S_ISSUE: begin
          mask     <= end_sel;
          wd       <= '0;
          err_pend <= (op_r == 2'd3);
        end
        S_WAIT: begin
          mask <= merged;
          // Completion takes priority over a coincident timeout.
          if (!all_done) begin
            wd <= wd_inc;
            if (wd_hit) err_pend <= 1'b1;
          end
        end
        S_DONE: begin
          if (err_pend)             err_sticky_r <= 1'b1;
          else if (op_r == OP_FWD)  cnt          <= cnt + CNT_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready           = (state == S_IDLE);
  assign busy                = (state != S_IDLE);
  assign start_state2        = (state == S_ISSUE) && (op_r == OP_FWD);
  assign start_backprop      = (state == S_ISSUE) && (op_r == OP_BP);
  assign update_second_layer = (state == S_ISSUE) && (op_r == OP_UPD);
  assign done                = (state == S_DONE);
  assign err                 = (state == S_DONE) && err_pend;
  assign err_sticky          = err_sticky_r;
  assign fwd_count           = cnt;

endmodule

`default_nettype wire

// File: doc/second_layer_ctrl.md
Name: second_layer_ctrl

Overview:
- Command-driven sequencer for the array of NOUT second-layer cells (output neurons).
- Issues the shared start_state2, start_backprop and update_second_layer pulses to all cells.
- Collects the per-cell end_state2/end_state4 completion pulses into a sticky mask and reports one done/err per command.
- Sits between the top-level training/inference FSM and the cell array; also provides a watchdog and a forward-pass counter.

Parameters:
- NOUT, 10, number of second-layer cells (output neurons).
- TO_BITS, 12, width of the watchdog counter.
- TIMEOUT, 4000, maximum WAIT cycles before abort; must be < 2^TO_BITS.
- CNT_BITS, 16, width of the forward-pass counter.

Ports:
- clk  in  1  system clock
- reset_b  in  1  reset: synchronous, active-high
- cmd_valid  in  1  command request
- cmd_op  in  2  0=forward, 1=backprop, 2=update, 3=illegal
- cmd_ready  out  1  high only in IDLE
- start_state2  out  1  one-cycle forward start pulse to all cells
- start_backprop  out  1  one-cycle backprop start pulse to all cells
- update_second_layer  out  1  one-cycle weight/bias update pulse to all cells
- end_state2  in  NOUT  per-cell forward-done pulses
- end_state4  in  NOUT  per-cell backprop-done pulses
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle command completion pulse
- err  out  1  valid with done: timeout or illegal op
- err_sticky  out  1  set on any err; cleared only by reset
- fwd_count  out  CNT_BITS  count of successful forward passes

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - All outputs 0 except cmd_ready=1.
  - Mask, watchdog counter and fwd_count cleared.
  - Reset asserted mid-command aborts the command with no done pulse.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid & cmd_ready; cmd_op is latched into op_r on acceptance and the state moves to ISSUE.
  - end_* pulses arriving in IDLE are ignored.
- ISSUE (one cycle):
  - Drives exactly one of start_state2 / start_backprop / update_second_layer high, selected by op_r.
  - Clears the mask and the watchdog counter.
  - end_* bits present in this cycle are OR-ed into the cleared mask.
  - Next state: op=forward/backprop -> WAIT; op=update -> DONE (no completion collection).
  - op=3 -> DONE with err pending; no pulse is driven.
- WAIT:
  - mask <= mask | end_sel, where end_sel = end_state2 for forward, end_state4 for backprop; the other bus is ignored.
  - When (mask | end_sel) is all ones -> DONE, err=0.
  - Otherwise the watchdog increments each cycle; when it reaches TIMEOUT -> DONE with err=1.
  - If completion and timeout occur in the same cycle, completion wins (err=0).
- DONE (one cycle):
  - done=1; err per the cause recorded above.
  - On err, err_sticky <= 1.
  - On a successful forward, fwd_count increments and wraps modulo 2^CNT_BITS.
  - Next state: IDLE. cmd_ready returns the following cycle, so back-to-back commands have a one-cycle gap.
- Latency:
  - Accept at cycle T -> start pulse at T+1.
  - Last end bit at cycle E -> done at E+1.
  - Update command: done at T+2.
- Repeated end pulses from a cell already in the mask have no effect.
- busy = (state != IDLE); done and busy are both high in DONE.
- All outputs are registered or decoded directly from state; no combinational path from end_* to done.

Test Plan:
- Forward:
  - Stimulus: cmd_op=0 accepted at cycle 0; cells 0..9 pulse end_state2 at staggered cycles 260..269.
  - Required: start_state2 high only at cycle 1; done=1, err=0 at cycle 270; fwd_count=1; cmd_ready=1 at 271.
- Backprop:
  - Stimulus: cmd_op=1; all 10 end_state4 pulse together at cycle 300; end_state2 toggled throughout.
  - Required: start_backprop single pulse at cycle 1; end_state2 ignored; done at 301; fwd_count unchanged.
- Update and illegal op:
  - Stimulus: cmd_op=2, then cmd_op=3.
  - Required for op=2: update_second_layer pulses once; done at T+2, err=0.
  - Required for op=3: no pulse on any start output; done at T+2 with err=1; err_sticky=1.
- Timeout:
  - Stimulus: forward with cell 7 never pulsing, TIMEOUT=4000.
  - Required: done=1, err=1 exactly 4000 WAIT cycles after ISSUE; fwd_count unchanged; next command accepted normally.
- Reset mid-WAIT:
  - Stimulus: reset_b high for 1 cycle after 5 of 10 ends have arrived.
  - Required: state=IDLE, no done; a following forward requires all 10 fresh ends (mask cleared).
- Counter wrap and edge events:
  - Stimulus: 65536 forwards with CNT_BITS=16.
  - Required: fwd_count wraps to 0.
  - Stimulus: end pulse during ISSUE.
  - Required: that pulse is captured in the mask.
  - Stimulus: cmd_valid held high during a busy command.
  - Required: no extra acceptance until IDLE.
